// File: rtl/arb_pkt_mux.sv
// Packet-lock mux behind a round-robin arbiter: one source owns the output until its last beat or MAX_PKT beats.
// Latency grant->v_ready 1 cycle, beat->o_vld 1 cycle; v_ready drops only while the output register is full and o_ready is low.
module arb_pkt_mux #(
  parameter int WIDTH   = 4,
  parameter int DW      = 32,
  parameter int MAX_PKT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         v_vld,
  input  logic [WIDTH*DW-1:0]      v_data,
  input  logic [WIDTH-1:0]         v_last,
  output logic [WIDTH-1:0]         v_ready,
  output logic [WIDTH-1:0]         arb_req,
  input  logic [WIDTH-1:0]         arb_grant,
  output logic                     o_vld,
  output logic [DW-1:0]            o_data,
  output logic                     o_last,
  output logic [$clog2(WIDTH)-1:0] o_src,
  input  logic                     o_ready,
  output logic                     o_pkt_err,
  output logic                     o_gnt_err
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            o_vld_q, o_vld_d;
  logic [DW-1:0]   o_data_q, o_data_d;
  logic            o_last_q, o_last_d;
  logic [SW-1:0]   o_src_q, o_src_d;
  logic            pkt_err_q, pkt_err_d;
  logic            gnt_err_q, gnt_err_d;

  logic            sel_vld, sel_last;
  logic [DW-1:0]   sel_dat;
  logic [SW-1:0]   gnt_idx;
  logic            gnt_onehot, gnt_legal;
  logic            at_max, can_load, accept, close_pkt;

  always_comb begin
    sel_vld = 1'b0;
    sel_last = 1'b0;
    sel_dat = '0;
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_q == SW'(i)) begin
        sel_vld  = v_vld[i];
        sel_last = v_last[i];
        sel_dat  = v_data[i*DW +: DW];
      end
      if (arb_grant[i]) gnt_idx = SW'(i);
    end
    gnt_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - WIDTH'(1))) == '0);
    gnt_legal  = gnt_onehot && ((arb_grant & v_vld) != '0);
    at_max     = (cnt_q == CW'(MAX_PKT - 1));
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    o_vld_d   = o_vld_q & ~o_ready;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    o_src_d   = o_src_q;
    pkt_err_d = 1'b0;
    gnt_err_d = 1'b0;
    arb_req   = '0;
    v_ready   = '0;
    can_load  = 1'b0;
    accept    = 1'b0;
    close_pkt = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so the arbiter sees no requests while reset is held.
        arb_req = rst_n ? v_vld : '0;
        if (gnt_legal) begin
          sel_d   = gnt_idx;
          cnt_d   = '0;
          state_d = LOCK;
        end else if (arb_grant != '0) begin
          gnt_err_d = 1'b1;
        end
      end
      LOCK: begin
        can_load       = ~o_vld_q | o_ready;
        v_ready[sel_q] = can_load;
        accept         = sel_vld & can_load;
        if (accept) begin
          close_pkt = sel_last | at_max;
          o_vld_d   = 1'b1;
          o_data_d  = sel_dat;
          o_src_d   = sel_q;
          o_last_d  = close_pkt;
          cnt_d     = cnt_q + CW'(1);
          if (close_pkt) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
          pkt_err_d = at_max & ~sel_last;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      o_vld_q   <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_src_q   <= '0;
      pkt_err_q <= 1'b0;
      gnt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      o_vld_q   <= o_vld_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_src_q   <= o_src_d;
      pkt_err_q <= pkt_err_d;
      gnt_err_q <= gnt_err_d;
    end
  end

  assign o_vld     = o_vld_q;
  assign o_data    = o_data_q;
  assign o_last    = o_last_q;
  assign o_src     = o_src_q;
  assign o_pkt_err = pkt_err_q;
  assign o_gnt_err = gnt_err_q;

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Directed + randomized bench for arb_pkt_mux; a behavioural round-robin grant source stands in for arb_rr.
module tb_arb_pkt_mux;
  localparam int W  = 4;
  localparam int DW = 8;
  localparam int MP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    v_vld = '0;
  logic [W*DW-1:0] v_data = '0;
  logic [W-1:0]    v_last = '0;
  logic [W-1:0]    v_ready, arb_req, arb_grant;
  logic [W-1:0]    tb_grant = '0;
  logic            o_vld, o_last, o_pkt_err, o_gnt_err;
  logic [DW-1:0]   o_data;
  logic [1:0]      o_src;
  logic            o_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic rr_en = 1'b0;
  int   rr_ptr = 0;

  arb_pkt_mux #(.WIDTH(W), .DW(DW), .MAX_PKT(MP)) dut (
    .clk(clk), .rst_n(rst_n), .v_vld(v_vld), .v_data(v_data), .v_last(v_last),
    .v_ready(v_ready), .arb_req(arb_req), .arb_grant(arb_grant),
    .o_vld(o_vld), .o_data(o_data), .o_last(o_last), .o_src(o_src),
    .o_ready(o_ready), .o_pkt_err(o_pkt_err), .o_gnt_err(o_gnt_err)
  );

  always #5 clk = ~clk;

  // Round-robin grant: first requester at or after rr_ptr.
  always @* begin
    arb_grant = tb_grant;
    if (rr_en) begin
      arb_grant = '0;
      for (int k = W - 1; k >= 0; k--)
        if (arb_req[(rr_ptr + k) % W]) arb_grant = W'(1) << ((rr_ptr + k) % W);
    end
  end

  always @(posedge clk)
    if (rr_en)
      for (int k = 0; k < W; k++)
        if (arb_grant[k]) rr_ptr <= (k + 1) % W;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int s, input logic [7:0] d, input logic l);
    v_data[s*DW +: DW] = d;
    v_last[s] = l;
  endtask

  // Random-phase state
  logic [10:0] expq[$];
  logic [10:0] ebeat;
  logic [7:0]  dat[16];
  logic        lf[16];
  int          src, nb, bi, cyc, pcnt, perr_exp, pe_cnt, ge_cnt, es, eb, j;
  logic        acc1, lst;
  logic [W-1:0] acc;
  int          bc[W];

  task automatic rnd_sample();
    chk("rnd_rdy_other", 32'(v_ready & ~(W'(1) << src)), 0);
    if (o_pkt_err) pe_cnt++;
    if (o_gnt_err) ge_cnt++;
    if (o_vld && o_ready) begin
      n_tests++;
      assert (expq.size() > 0) else begin
        n_fail++;
        $error("FAIL rnd_extra observed=src%0d/%0h expected=no beat", o_src, o_data);
      end
      if (expq.size() > 0) begin
        ebeat = expq.pop_front();
        chk("rnd_beat", {o_src, o_data, o_last}, ebeat);
      end
    end
  endtask

  initial begin
    // Reset state, with valids asserted to show arb_req is forced low
    v_vld = 4'hF; o_ready = 1'b1;
    #12;
    chk("rst_out", {o_vld, o_last, o_src, o_data, o_pkt_err, o_gnt_err}, 0);
    chk("rst_req", arb_req, 0);
    chk("rst_rdy", v_ready, 0);
    @(negedge clk); rst_n = 1'b1; v_vld = '0;

    // Test 1: source 2, three-beat packet
    @(negedge clk); v_vld = 4'b0100; set_src(2, 8'hA0, 0); tb_grant = 4'b0100;
    #1 chk("t1_req", arb_req, 4'b0100); chk("t1_idle_rdy", v_ready, 0);
    @(negedge clk); tb_grant = '0;
    #1 chk("t1_rdy_lat", v_ready, 4'b0100); chk("t1_ovld0", o_vld, 0);
    @(negedge clk); set_src(2, 8'hA1, 0);
    #1 chk("t1_a0", {o_vld, o_data, o_last, o_src}, {1'b1, 8'hA0, 1'b0, 2'd2});
    @(negedge clk); set_src(2, 8'hA2, 1);
    #1 chk("t1_a1", {o_vld, o_data, o_last, o_src}, {1'b1, 8'hA1, 1'b0, 2'd2});
    @(negedge clk); v_vld = '0; set_src(2, 8'h00, 0);
    #1 chk("t1_a2", {o_vld, o_data, o_last, o_src}, {1'b1, 8'hA2, 1'b1, 2'd2});
    chk("t1_rel_rdy", v_ready, 0);
    @(negedge clk);
    #1 chk("t1_drain", o_vld, 0);

    // Test 5: multi-hot grant, then grant to a non-valid source
    @(negedge clk); v_vld = 4'b0001; tb_grant = 4'b0011;
    #1 chk("t5_rdy", v_ready, 0);
    @(negedge clk); tb_grant = '0;
    #1 chk("t5_err_mh", o_gnt_err, 1); chk("t5_idle", arb_req, 4'b0001); chk("t5_rdy2", v_ready, 0);
    @(negedge clk); tb_grant = 4'b0100;
    #1 chk("t5_err_clr", o_gnt_err, 0);
    @(negedge clk); tb_grant = '0;
    #1 chk("t5_err_nv", o_gnt_err, 1); chk("t5_rdy3", v_ready, 0);
    @(negedge clk); v_vld = '0;

    // Test 4: source 3 under backpressure
    @(negedge clk); v_vld = 4'b1000; set_src(3, 8'hB0, 0); tb_grant = 4'b1000;
    @(negedge clk); tb_grant = '0;
    @(negedge clk); set_src(3, 8'hB1, 0); o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_hold", {o_vld, o_data}, {1'b1, 8'hB0});
      chk("t4_stall", v_ready, 0);
      @(negedge clk);
    end
    o_ready = 1'b1;
    #1 chk("t4_resume", v_ready, 4'b1000);
    @(negedge clk); set_src(3, 8'hB2, 1);
    #1 chk("t4_b1", {o_vld, o_data, o_last, o_src}, {1'b1, 8'hB1, 1'b0, 2'd3});
    @(negedge clk); v_vld = '0;
    #1 chk("t4_b2", {o_vld, o_data, o_last, o_src}, {1'b1, 8'hB2, 1'b1, 2'd3});
    @(negedge clk);

    // Test 6: reset in the middle of a packet
    @(negedge clk); v_vld = 4'b0010; set_src(1, 8'hC0, 0); tb_grant = 4'b0010;
    @(negedge clk); tb_grant = '0;
    @(negedge clk); set_src(1, 8'hC1, 0);
    #2 rst_n = 1'b0;
    #1 chk("t6_out", {o_vld, o_last, o_src, o_data, o_pkt_err, o_gnt_err}, 0);
    chk("t6_rdy", v_ready, 0); chk("t6_req", arb_req, 0);
    @(negedge clk); rst_n = 1'b1; v_vld = 4'b0001; set_src(0, 8'hD0, 1); tb_grant = 4'b0001;
    @(negedge clk); tb_grant = '0;
    #1 chk("t6_regrant", v_ready, 4'b0001);
    @(negedge clk); v_vld = '0;
    #1 chk("t6_d0", {o_vld, o_data, o_last, o_src}, {1'b1, 8'hD0, 1'b1, 2'd0});
    chk("t6_no_perr", o_pkt_err, 0);
    @(negedge clk);

    // Test 2: all sources valid, round-robin grants, two 2-beat packets each
    for (int s = 0; s < W; s++) bc[s] = 0;
    rr_en = 1'b1; o_ready = 1'b1; j = 0; cyc = 0;
    while (j < 16 && cyc < 300) begin
      for (int s = 0; s < W; s++) begin
        v_vld[s] = (bc[s] < 4);
        set_src(s, 8'((s << 4) | bc[s]), (bc[s] % 2) == 1);
      end
      #1 acc = v_vld & v_ready;
      if (o_vld && o_ready) begin
        es = (j / 2) % 4;
        eb = 2 * (j / 8) + j % 2;
        chk("rr_beat", {o_src, o_data, o_last}, {2'(es), 8'((es << 4) | eb), 1'(eb % 2)});
        j++;
      end
      @(posedge clk);
      for (int s = 0; s < W; s++) if (acc[s]) bc[s]++;
      @(negedge clk);
      cyc++;
    end
    chk("rr_count", j, 16);
    rr_en = 1'b0; v_vld = '0;
    @(negedge clk);

    // Randomized single-source packet streams against the reference model
    pe_cnt = 0; ge_cnt = 0; perr_exp = 0;
    for (int t = 0; t < 40; t++) begin
      src = $urandom_range(0, W - 1);
      nb  = $urandom_range(1, 9);
      pcnt = 0;
      for (int b = 0; b < nb; b++) begin
        dat[b] = 8'($urandom);
        lf[b]  = (b == nb - 1) || ($urandom_range(0, 3) == 0);
        lst    = lf[b] || (pcnt == MP - 1);
        if (pcnt == MP - 1 && !lf[b]) perr_exp++;
        expq.push_back({2'(src), dat[b], lst});
        pcnt = lst ? 0 : pcnt + 1;
      end
      bi = 0; cyc = 0;
      while (bi < nb && cyc < 300) begin
        v_vld = ($urandom_range(0, 4) == 0) ? '0 : (W'(1) << src);
        set_src(src, dat[bi], lf[bi]);
        o_ready = ($urandom_range(0, 3) != 0);
        #1 tb_grant = arb_req[src] ? (W'(1) << src) : '0;
        #1 acc1 = v_vld[src] & v_ready[src];
        rnd_sample();
        @(posedge clk);
        if (acc1) bi++;
        @(negedge clk);
        cyc++;
      end
      chk("rnd_progress", bi, nb);
      v_vld = '0; tb_grant = '0; o_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
        #2 rnd_sample();
        @(negedge clk);
      end
      chk("rnd_qempty", expq.size(), 0);
      expq.delete();
      set_src(src, 8'h00, 0);
    end
    chk("rnd_pkt_err", pe_cnt, perr_exp);
    chk("rnd_gnt_err", ge_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
